// File: rtl/cosim_commit_arbiter.sv
// cosim_commit_arbiter
//   Gathers per-hart retirement records into per-hart FIFOs and serialises them,
//   round-robin, onto a single valid/ready stream feeding the Spike scoreboard.
//   A hart's records are forwarded only once it has committed at START_PC.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   in_valid[h]       per-hart commit strobe (no back-pressure)
//   in_pc/in_instr/in_dest/in_wen/in_data/in_excep/in_cause   flattened per-hart record fields
//   out_valid/out_ready                                       output handshake
//   out_hart, out_pc ... out_cause                            serialised record
//   compare_active[h] hart has committed at START_PC
//   overflow[h]       sticky: a record was dropped on a full FIFO
//   timeout           sticky: output stalled TIMEOUT_CYC consecutive cycles
//
// Optional feature: define COSIM_COMMIT_STATS_EN to add commit_cnt / drop_cnt
// (per-hart saturating 32-bit counters of accepted pushes and overflow drops).

module cosim_commit_arbiter #(
  parameter int unsigned N_HARTS     = 4,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [63:0] START_PC    = 64'h8000_0000,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_HARTS-1:0]     in_valid,
  input  logic [N_HARTS*64-1:0]  in_pc,
  input  logic [N_HARTS*32-1:0]  in_instr,
  input  logic [N_HARTS*5-1:0]   in_dest,
  input  logic [N_HARTS-1:0]     in_wen,
  input  logic [N_HARTS*64-1:0]  in_data,
  input  logic [N_HARTS-1:0]     in_excep,
  input  logic [N_HARTS*64-1:0]  in_cause,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [3:0]             out_hart,
  output logic [63:0]            out_pc,
  output logic [31:0]            out_instr,
  output logic [4:0]             out_dest,
  output logic                   out_wen,
  output logic [63:0]            out_data,
  output logic                   out_excep,
  output logic [63:0]            out_cause,
  output logic [N_HARTS-1:0]     compare_active,
  output logic [N_HARTS-1:0]     overflow,
  output logic                   timeout
`ifdef COSIM_COMMIT_STATS_EN
  ,
  output logic [N_HARTS*32-1:0]  commit_cnt,
  output logic [N_HARTS*32-1:0]  drop_cnt
`endif
);

  localparam int unsigned PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned StallW = $clog2(TIMEOUT_CYC + 1);

  // 231-bit retirement record
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [4:0]  dest;
    logic        wen;
    logic [63:0] data;
    logic        excep;
    logic [63:0] cause;
  } rec_t;

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  // Per-hart FIFO state
  rec_t            mem_q    [N_HARTS][FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q [N_HARTS];
  logic [PtrW-1:0] wr_ptr_d [N_HARTS];
  logic [PtrW-1:0] rd_ptr_q [N_HARTS];
  logic [PtrW-1:0] rd_ptr_d [N_HARTS];
  logic [CntW-1:0] cnt_q    [N_HARTS];
  logic [CntW-1:0] cnt_d    [N_HARTS];

  rec_t               in_rec [N_HARTS];
  logic [N_HARTS-1:0] push_req, accept, drop, pop, nonempty, full;
  logic [N_HARTS-1:0] active_q, active_d, overflow_q, overflow_d;

  // Arbiter / output stage
  logic [3:0]        rr_ptr_q, rr_ptr_d, winner;
  logic              found, grant;
  rec_t              win_rec;
  state_e            state_q, state_d;
  rec_t              out_rec_q, out_rec_d;
  logic [3:0]        out_hart_q, out_hart_d;
  logic [StallW-1:0] stall_q, stall_d;
  logic              timeout_q, timeout_d;

`ifdef COSIM_COMMIT_STATS_EN
  logic [31:0] commit_cnt_q [N_HARTS];
  logic [31:0] commit_cnt_d [N_HARTS];
  logic [31:0] drop_cnt_q   [N_HARTS];
  logic [31:0] drop_cnt_d   [N_HARTS];
`endif

  // Input gating and FIFO status
  always_comb begin
    for (int h = 0; h < N_HARTS; h++) begin
      in_rec[h].pc    = in_pc[h*64 +: 64];
      in_rec[h].instr = in_instr[h*32 +: 32];
      in_rec[h].dest  = in_dest[h*5 +: 5];
      in_rec[h].wen   = in_wen[h];
      in_rec[h].data  = in_data[h*64 +: 64];
      in_rec[h].excep = in_excep[h];
      in_rec[h].cause = in_cause[h*64 +: 64];
      push_req[h] = in_valid[h] && (active_q[h] || (in_pc[h*64 +: 64] == START_PC));
      nonempty[h] = (cnt_q[h] != '0);
      full[h]     = (cnt_q[h] == CntW'(FIFO_DEPTH));
    end
  end

  // Round-robin arbiter: first non-empty hart at or after rr_ptr_q
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    rr_ptr_d = rr_ptr_q;
    pop      = '0;
    win_rec  = '0;
    for (int i = 0; i < N_HARTS; i++) begin
      for (int h = 0; h < N_HARTS; h++) begin
        if (!found && nonempty[h] && (((int'(rr_ptr_q) + i) % int'(N_HARTS)) == h)) begin
          found  = 1'b1;
          winner = 4'(h);
        end
      end
    end
    // Output stage can take a record when empty or when its record leaves this cycle
    grant = found && ((state_q == StEmpty) || out_ready);
    if (grant) begin
      rr_ptr_d = (winner == 4'(N_HARTS - 1)) ? 4'd0 : winner + 4'd1;
    end
    for (int h = 0; h < N_HARTS; h++) begin
      if (grant && (winner == 4'(h))) begin
        pop[h]  = 1'b1;
        win_rec = mem_q[h][rd_ptr_q[h]];
      end
    end
  end

  // FIFO pointer/occupancy and sticky flag next-state
  always_comb begin
    for (int h = 0; h < N_HARTS; h++) begin
      // A full FIFO still accepts when its head leaves in the same cycle
      accept[h]   = push_req[h] && (!full[h] || pop[h]);
      drop[h]     = push_req[h] && full[h] && !pop[h];
      wr_ptr_d[h] = accept[h] ? wr_ptr_q[h] + PtrW'(1) : wr_ptr_q[h];
      rd_ptr_d[h] = pop[h] ? rd_ptr_q[h] + PtrW'(1) : rd_ptr_q[h];
      cnt_d[h]    = cnt_q[h];
      if (accept[h] && !pop[h]) begin
        cnt_d[h] = cnt_q[h] + CntW'(1);
      end else if (!accept[h] && pop[h]) begin
        cnt_d[h] = cnt_q[h] - CntW'(1);
      end
    end
    active_d   = active_q | push_req;
    overflow_d = overflow_q | drop;
  end

  // Output stage FSM and stall watchdog
  always_comb begin
    state_d    = state_q;
    out_rec_d  = out_rec_q;
    out_hart_d = out_hart_q;
    unique case (state_q)
      StEmpty: begin
        if (grant) begin
          state_d    = StFull;
          out_rec_d  = win_rec;
          out_hart_d = winner;
        end
      end
      StFull: begin
        if (out_ready) begin
          if (grant) begin
            out_rec_d  = win_rec;
            out_hart_d = winner;
          end else begin
            state_d = StEmpty;
          end
        end
      end
      default: state_d = StEmpty;
    endcase

    stall_d = '0;
    if ((state_q == StFull) && !out_ready) begin
      stall_d = (stall_q == StallW'(TIMEOUT_CYC)) ? stall_q : stall_q + StallW'(1);
    end
    timeout_d = timeout_q || (stall_d == StallW'(TIMEOUT_CYC));
  end

`ifdef COSIM_COMMIT_STATS_EN
  always_comb begin
    for (int h = 0; h < N_HARTS; h++) begin
      commit_cnt_d[h] = commit_cnt_q[h];
      drop_cnt_d[h]   = drop_cnt_q[h];
      if (accept[h] && (commit_cnt_q[h] != '1)) commit_cnt_d[h] = commit_cnt_q[h] + 32'd1;
      if (drop[h] && (drop_cnt_q[h] != '1))     drop_cnt_d[h]   = drop_cnt_q[h] + 32'd1;
      commit_cnt[h*32 +: 32] = commit_cnt_q[h];
      drop_cnt[h*32 +: 32]   = drop_cnt_q[h];
    end
  end
`endif

  // FIFO storage needs no reset; pointers/occupancy define validity
  always_ff @(posedge clk) begin
    for (int h = 0; h < N_HARTS; h++) begin
      if (accept[h]) mem_q[h][wr_ptr_q[h]] <= in_rec[h];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int h = 0; h < N_HARTS; h++) begin
        wr_ptr_q[h] <= '0;
        rd_ptr_q[h] <= '0;
        cnt_q[h]    <= '0;
`ifdef COSIM_COMMIT_STATS_EN
        commit_cnt_q[h] <= '0;
        drop_cnt_q[h]   <= '0;
`endif
      end
      active_q   <= '0;
      overflow_q <= '0;
      rr_ptr_q   <= '0;
      state_q    <= StEmpty;
      out_rec_q  <= '0;
      out_hart_q <= '0;
      stall_q    <= '0;
      timeout_q  <= 1'b0;
    end else begin
      for (int h = 0; h < N_HARTS; h++) begin
        wr_ptr_q[h] <= wr_ptr_d[h];
        rd_ptr_q[h] <= rd_ptr_d[h];
        cnt_q[h]    <= cnt_d[h];
`ifdef COSIM_COMMIT_STATS_EN
        commit_cnt_q[h] <= commit_cnt_d[h];
        drop_cnt_q[h]   <= drop_cnt_d[h];
`endif
      end
      active_q   <= active_d;
      overflow_q <= overflow_d;
      rr_ptr_q   <= rr_ptr_d;
      state_q    <= state_d;
      out_rec_q  <= out_rec_d;
      out_hart_q <= out_hart_d;
      stall_q    <= stall_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    out_valid      = (state_q == StFull);
    out_hart       = out_hart_q;
    out_pc         = out_rec_q.pc;
    out_instr      = out_rec_q.instr;
    out_dest       = out_rec_q.dest;
    out_wen        = out_rec_q.wen;
    out_data       = out_rec_q.data;
    out_excep      = out_rec_q.excep;
    out_cause      = out_rec_q.cause;
    compare_active = active_q;
    overflow       = overflow_q;
    timeout        = timeout_q;
  end

endmodule
